// File: rtl/time_calculate_pkg.sv
// time_calculate_pkg: default widths and timestamp type shared by the elapsed-time block.
package time_calculate_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TOTAL_WIDTH = 16;
  localparam int DEF_COUNT_WIDTH = 8;
  typedef logic [DEF_WIDTH-1:0] timestamp_t;
endpackage

// File: rtl/time_calculate_if.sv
// time_calculate_if: timestamp pair in, elapsed time and running totals out.
interface time_calculate_if
  import time_calculate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);
  logic in_valid;
  logic [WIDTH-1:0] time_out;
  logic [WIDTH-1:0] time_in;
  logic clear_total;
  logic [WIDTH-1:0] time_diff;
  logic out_valid;
  logic wrapped;
  logic [TOTAL_WIDTH-1:0] total_time;
  logic [COUNT_WIDTH-1:0] session_count;
  logic total_sat;
  modport master (
    output in_valid, time_out, time_in, clear_total,
    input time_diff, out_valid, wrapped, total_time, session_count, total_sat
  );
  modport slave (
    input in_valid, time_out, time_in, clear_total,
    output time_diff, out_valid, wrapped, total_time, session_count, total_sat
  );
endinterface

// File: rtl/time_calculate_sat_accumulator.sv
// sat_accumulator: saturating adder register with synchronous clear and sticky saturation flag.
module sat_accumulator #(
  parameter int W = 16,
  parameter int IW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic [IW-1:0] inc,
  output logic [W-1:0] sum,
  output logic sat
);
  logic [W:0] sum_ext;
  assign sum_ext = {1'b0, sum} + (W+1)'(inc);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (en) begin
      sum <= sum_ext[W] ? '1 : sum_ext[W-1:0];
      sat <= sat | sum_ext[W];
    end
  end
endmodule

// File: rtl/time_calculate.sv
// time_calculate: registered elapsed time between timestamps with saturating total and session count.
module time_calculate
  import time_calculate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input logic clk,
  input logic rst,
  time_calculate_if.slave bus
);
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.time_diff <= '0;
      bus.wrapped <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.session_count <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.time_diff <= bus.time_out - bus.time_in;
        bus.wrapped <= bus.time_in > bus.time_out;
      end
      // clear wins over a same-cycle accepted pair
      if (bus.clear_total)
        bus.session_count <= '0;
      else if (bus.in_valid && bus.session_count != '1)
        bus.session_count <= bus.session_count + 1'b1;
    end
  end
  sat_accumulator #(.W(TOTAL_WIDTH), .IW(WIDTH)) u_total (
    .clk(clk),
    .rst(rst),
    .clear(bus.clear_total),
    .en(bus.in_valid),
    .inc(bus.time_out - bus.time_in),
    .sum(bus.total_time),
    .sat(bus.total_sat)
  );
endmodule

// File: tb/tb_time_calculate.sv
// tb_time_calculate: directed checks of elapsed time, wrap, saturating total, clear and reset.
module tb_time_calculate;
  import time_calculate_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  time_calculate_if bus ();
  time_calculate dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input timestamp_t t_out,
                      input timestamp_t t_in, input logic clr);
    rst = r;
    bus.in_valid = v;
    bus.time_out = t_out;
    bus.time_in = t_in;
    bus.clear_total = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_diff"}, 32'(bus.time_diff), 0);
    chk({tag, "_ov"}, 32'(bus.out_valid), 0);
    chk({tag, "_wrap"}, 32'(bus.wrapped), 0);
    chk({tag, "_total"}, 32'(bus.total_time), 0);
    chk({tag, "_count"}, 32'(bus.session_count), 0);
    chk({tag, "_sat"}, 32'(bus.total_sat), 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_zero("reset");
    step(0, 1, 250, 100, 0);
    chk("p1_diff", 32'(bus.time_diff), 150);
    chk("p1_wrap", 32'(bus.wrapped), 0);
    chk("p1_ov", 32'(bus.out_valid), 1);
    step(0, 1, 85, 32, 0);
    chk("p2_diff", 32'(bus.time_diff), 53);
    chk("p2_ov", 32'(bus.out_valid), 1);
    step(0, 1, 255, 0, 0);
    chk("p3_diff", 32'(bus.time_diff), 255);
    chk("p3_wrap", 32'(bus.wrapped), 0);
    step(0, 1, 144, 144, 0);
    chk("p4_diff", 32'(bus.time_diff), 0);
    chk("p4_wrap", 32'(bus.wrapped), 0);
    step(0, 0, 0, 0, 0);
    chk("idle_ov", 32'(bus.out_valid), 0);
    chk("four_total", 32'(bus.total_time), 458);
    chk("four_count", 32'(bus.session_count), 4);
    step(0, 1, 10, 250, 0);
    chk("wrap_diff", 32'(bus.time_diff), 16);
    chk("wrap_wrap", 32'(bus.wrapped), 1);
    chk("wrap_total", 32'(bus.total_time), 474);
    step(0, 0, 33, 1, 0);
    chk("hold_diff", 32'(bus.time_diff), 16);
    chk("hold_wrap", 32'(bus.wrapped), 1);
    chk("hold_ov", 32'(bus.out_valid), 0);
    // 474 + 255*255 = 65499 stays below the clamp; the 256th pair overflows
    for (int i = 0; i < 255; i++) step(0, 1, 255, 0, 0);
    chk("presat_total", 32'(bus.total_time), 65499);
    chk("presat_sat", 32'(bus.total_sat), 0);
    chk("presat_count", 32'(bus.session_count), 255);
    step(0, 1, 255, 0, 0);
    chk("sat_total", 32'(bus.total_time), 65535);
    chk("sat_flag", 32'(bus.total_sat), 1);
    for (int i = 0; i < 44; i++) step(0, 1, 255, 0, 0);
    chk("b2b_total", 32'(bus.total_time), 65535);
    chk("b2b_sat", 32'(bus.total_sat), 1);
    chk("b2b_count", 32'(bus.session_count), 255);
    chk("b2b_ov", 32'(bus.out_valid), 1);
    step(0, 1, 50, 20, 1);
    chk("clr_total", 32'(bus.total_time), 0);
    chk("clr_count", 32'(bus.session_count), 0);
    chk("clr_sat", 32'(bus.total_sat), 0);
    chk("clr_diff", 32'(bus.time_diff), 30);
    chk("clr_ov", 32'(bus.out_valid), 1);
    step(0, 1, 7, 3, 0);
    chk("post_clr_total", 32'(bus.total_time), 4);
    chk("post_clr_count", 32'(bus.session_count), 1);
    step(1, 1, 200, 100, 0);
    chk_zero("midrst");
    step(0, 0, 0, 0, 0);
    chk("after_rst_total", 32'(bus.total_time), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
